disp_colour_adapt: RTL and testbench

//  Parametrised pixel output stage between the display core and the TMDS/DVI encoder on the pixel clock.

---
 rtl/disp_colour_adapt_pkg.sv | 32 +++
 rtl/disp_colour_adapt_if.sv | 26 ++
 rtl/disp_colour_adapt_chan.sv | 53 +++++
 rtl/disp_colour_adapt.sv | 132 +++++++++++++
 tb/tb_disp_colour_adapt.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/disp_colour_adapt_pkg.sv
// Shared definitions for the display colour adapter: mode encodings,
// the 4x4 Bayer ordered-dither table and threshold scaling.
package disp_colour_adapt_pkg;

    localparam logic [1:0] DISP_MODE_PLAIN    = 2'd0;
    localparam logic [1:0] DISP_MODE_SPATIAL  = 2'd1;
    localparam logic [1:0] DISP_MODE_TEMPORAL = 2'd2;
    localparam logic [1:0] DISP_MODE_BLANK    = 2'd3;

    // 4x4 Bayer matrix, row = y, column = x, values 0..15
    function automatic logic [3:0] bayer4(input logic [1:0] y, input logic [1:0] x);
        logic [3:0] v;
        case ({y, x})
            4'd0:  v = 4'd0;   4'd1:  v = 4'd8;   4'd2:  v = 4'd2;   4'd3:  v = 4'd10;
            4'd4:  v = 4'd12;  4'd5:  v = 4'd4;   4'd6:  v = 4'd14;  4'd7:  v = 4'd6;
            4'd8:  v = 4'd3;   4'd9:  v = 4'd11;  4'd10: v = 4'd1;   4'd11: v = 4'd9;
            4'd12: v = 4'd15;  4'd13: v = 4'd7;   4'd14: v = 4'd13;  default: v = 4'd5;
        endcase
        return v;
    endfunction

    // Stretch a 4-bit threshold to span the d bits being discarded
    function automatic int thr_scale(input logic [3:0] t, input int d);
        if (d <= 0)
            return 0;
        else if (d <= 4)
            return int'(t) >> (4 - d);
        else
            return int'(t) << (d - 4);
    endfunction

endpackage

// File: rtl/disp_colour_adapt_if.sv
// Video bus between display core, colour adapter and encoder.
// master drives the input side and observes the output; slave is the adapter.
interface disp_colour_adapt_if #(
    parameter int CHAN    = 3,
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
);
    logic                      in_hsync;
    logic                      in_vsync;
    logic                      in_de;
    logic [CHAN*BPC_IN-1:0]    in_colr;
    logic                      out_hsync;
    logic                      out_vsync;
    logic                      out_de;
    logic [CHAN*BPC_OUT-1:0]   out_colr;

    modport master (
        output in_hsync, in_vsync, in_de, in_colr,
        input  out_hsync, out_vsync, out_de, out_colr
    );

    modport slave (
        input  in_hsync, in_vsync, in_de, in_colr,
        output out_hsync, out_vsync, out_de, out_colr
    );
endinterface

// File: rtl/disp_colour_adapt_chan.sv
// One colour channel: threshold add (stage 1), then saturate / width
// select / blank (stage 2). Widening replicates the input MSB-first.
module disp_colour_chan
    import disp_colour_adapt_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    input  logic [BPC_IN-1:0]  i_colr,
    input  logic [BPC_IN:0]    i_thr,    // already zero when not dithering
    input  logic               i_kill,   // stage-1 aligned: DE low or blank mode
    output logic [BPC_OUT-1:0] o_colr
);
    logic [BPC_IN:0]    w_sum;
    logic [BPC_IN:0]    r_sum;
    logic [BPC_OUT-1:0] w_sel;
    logic [BPC_OUT-1:0] r_out;

    // extra top bit catches the carry so bright pixels saturate instead of wrapping
    assign w_sum = {1'b0, i_colr} + i_thr;

    // stage 1: register the dithered sum
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) r_sum <= '0;
        else            r_sum <= w_sum;
    end

    generate
        if (BPC_OUT < BPC_IN) begin : g_narrow
            logic w_unused_lo;
            assign w_sel       = r_sum[BPC_IN] ? '1 : r_sum[BPC_IN-1 -: BPC_OUT];
            assign w_unused_lo = ^r_sum[BPC_IN-BPC_OUT-1:0];
        end else begin : g_wide
            // equal widths fall out as REP=1, a straight passthrough
            localparam int REP = (BPC_OUT + BPC_IN - 1) / BPC_IN;
            logic [REP*BPC_IN-1:0] w_rep;
            logic                  w_unused_wd;
            assign w_rep       = {REP{r_sum[BPC_IN-1:0]}};
            assign w_sel       = w_rep[REP*BPC_IN-1 -: BPC_OUT];
            assign w_unused_wd = r_sum[BPC_IN] ^ (^w_rep);
        end
    endgenerate

    // stage 2: blank outside active video, otherwise selected colour
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) r_out <= '0;
        else            r_out <= i_kill ? '0 : w_sel;
    end

    assign o_colr = r_out;
endmodule

// File: rtl/disp_colour_adapt.sv
// Pixel output stage: colour width conversion with optional Bayer dither,
// frame-synchronous mode latch, sync/DE delay matched to the colour path.
module disp_colour_adapt
    import disp_colour_adapt_pkg::*;
#(
    parameter int   CHAN      = 3,
    parameter int   BPC_IN    = 5,
    parameter int   BPC_OUT   = 8,
    parameter int   LAT       = 2,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic                 clk_pix,
    input  logic                 rst_pix_n,
    input  logic [1:0]           mode,
    disp_colour_adapt_if.slave   vid
);
    localparam int D     = (BPC_IN > BPC_OUT) ? BPC_IN - BPC_OUT : 0;
    localparam int THR_W = BPC_IN + 1;
    localparam int OW    = CHAN * BPC_OUT;
    localparam int PW    = 3 + OW;
    localparam logic [PW-1:0] P_RST = {~HSYNC_POL, ~VSYNC_POL, 1'b0, {OW{1'b0}}};

    logic [1:0]       r_mode_act, r_xc, r_yc, r_fc;
    logic             r_de_prev, r_vs_prev;
    logic             w_vs_edge, w_de_fall, w_dith;
    logic [1:0]       w_bx, w_by;
    logic [THR_W-1:0] w_thr;
    logic             r_hs1, r_vs1, r_de1, r_blank1;
    logic             r_hs2, r_vs2, r_de2;
    logic             w_kill;
    logic [OW-1:0]    w_colr2;
    logic [PW-1:0]    w_st2, w_out;

    assign w_vs_edge = (vid.in_vsync == VSYNC_POL) && (r_vs_prev != VSYNC_POL);
    assign w_de_fall = r_de_prev && !vid.in_de;

    // screen position, frame phase and frame-synchronous mode latch
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_mode_act <= DISP_MODE_PLAIN;
            r_xc       <= '0;
            r_yc       <= '0;
            r_fc       <= '0;
            r_de_prev  <= 1'b0;
            r_vs_prev  <= ~VSYNC_POL;
        end else begin
            r_de_prev <= vid.in_de;
            r_vs_prev <= vid.in_vsync;
            r_xc      <= vid.in_de ? r_xc + 2'd1 : 2'd0;
            if (w_vs_edge) begin
                // clearing yc takes priority over a coincident DE fall
                r_yc       <= '0;
                r_fc       <= r_fc + 2'd1;
                r_mode_act <= mode;
            end else if (w_de_fall) begin
                r_yc <= r_yc + 2'd1;
            end
        end
    end

    // temporal mode walks the 2x2 neighbourhood over four frames
    assign w_bx   = (r_mode_act == DISP_MODE_TEMPORAL) ? (r_xc ^ {1'b0, r_fc[0]}) : r_xc;
    assign w_by   = (r_mode_act == DISP_MODE_TEMPORAL) ? (r_yc ^ {1'b0, r_fc[1]}) : r_yc;
    assign w_dith = (D > 0) && ((r_mode_act == DISP_MODE_SPATIAL) ||
                                (r_mode_act == DISP_MODE_TEMPORAL));
    assign w_thr  = w_dith ? THR_W'(thr_scale(bayer4(w_by, w_bx), D)) : '0;

    // stage 1/2 sync, DE and blank delay alongside the colour channels
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_hs1    <= ~HSYNC_POL;
            r_vs1    <= ~VSYNC_POL;
            r_de1    <= 1'b0;
            r_blank1 <= 1'b0;
            r_hs2    <= ~HSYNC_POL;
            r_vs2    <= ~VSYNC_POL;
            r_de2    <= 1'b0;
        end else begin
            r_hs1    <= vid.in_hsync;
            r_vs1    <= vid.in_vsync;
            r_de1    <= vid.in_de;
            r_blank1 <= (r_mode_act == DISP_MODE_BLANK);
            r_hs2    <= r_hs1;
            r_vs2    <= r_vs1;
            r_de2    <= r_de1;
        end
    end

    assign w_kill = !r_de1 || r_blank1;

    generate
        for (genvar c = 0; c < CHAN; c++) begin : g_chan
            disp_colour_chan #(
                .BPC_IN  (BPC_IN),
                .BPC_OUT (BPC_OUT)
            ) u_chan (
                .clk_pix   (clk_pix),
                .rst_pix_n (rst_pix_n),
                .i_colr    (vid.in_colr[c*BPC_IN +: BPC_IN]),
                .i_thr     (w_thr),
                .i_kill    (w_kill),
                .o_colr    (w_colr2[c*BPC_OUT +: BPC_OUT])
            );
        end
    endgenerate

    assign w_st2 = {r_hs2, r_vs2, r_de2, w_colr2};

    generate
        if (LAT > 2) begin : g_dly
            logic [PW-1:0] r_dly [LAT-2];
            // plain delay stages to reach the requested latency
            always_ff @(posedge clk_pix or negedge rst_pix_n) begin
                if (!rst_pix_n) begin
                    for (int i = 0; i < LAT-2; i++) r_dly[i] <= P_RST;
                end else begin
                    r_dly[0] <= w_st2;
                    for (int i = 1; i < LAT-2; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_out = r_dly[LAT-3];
        end else begin : g_nodly
            assign w_out = w_st2;
        end
    endgenerate

    assign vid.out_hsync = w_out[PW-1];
    assign vid.out_vsync = w_out[PW-2];
    assign vid.out_de    = w_out[PW-3];
    assign vid.out_colr  = w_out[OW-1:0];
endmodule

// File: tb/tb_disp_colour_adapt.sv
// Bench: a widening (5->8, LAT 2) and a narrowing (8->5, LAT 3) adapter
// fed the same timing; a behavioural model queues expected outputs.
module tb_disp_colour_adapt;
    localparam int LW = 2;
    localparam int LN = 3;

    typedef struct {
        logic        hs, vs, de;
        logic [23:0] colr;
        bit          cnt;
        int          pos;
    } exp_t;

    logic       clk_pix   = 1'b0;
    logic       rst_pix_n = 1'b1;
    logic [1:0] mode      = 2'd0;

    int   ncmp = 0, nerr = 0;
    exp_t qw[$], qn[$];
    int   bay[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    int   m_xc, m_yc, m_fc, m_mode;
    bit   m_de_p, m_vs_p;
    bit   cnt_on = 0;
    int   n_one, n_zero;
    int   pos_ones[16];

    always #5 clk_pix = ~clk_pix;

    disp_colour_adapt_if #(.CHAN(3), .BPC_IN(5), .BPC_OUT(8)) vw();
    disp_colour_adapt_if #(.CHAN(3), .BPC_IN(8), .BPC_OUT(5)) vn();

    disp_colour_adapt #(.CHAN(3), .BPC_IN(5), .BPC_OUT(8), .LAT(LW),
                        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_wide (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode), .vid(vw));
    disp_colour_adapt #(.CHAN(3), .BPC_IN(8), .BPC_OUT(5), .LAT(LN),
                        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) u_nar (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .mode(mode), .vid(vn));

    function automatic logic [7:0] wid(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    function automatic logic [4:0] nar(input logic [7:0] v, input int t, input int md);
        int s;
        if (md == 0 || md == 3) return v[7:3];
        s = int'(v) + (t >> 1);
        if (s > 255) return 5'h1F;
        return 5'(s >> 3);
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_push(input logic hs, input logic vs, input logic de,
                              input logic [14:0] cw, input logic [23:0] cn);
        exp_t ew, en;
        int   yy, xx, t;
        bit   vs_edge;
        vw.in_hsync = hs; vw.in_vsync = vs; vw.in_de = de; vw.in_colr = cw;
        vn.in_hsync = hs; vn.in_vsync = vs; vn.in_de = de; vn.in_colr = cn;
        yy = (m_mode == 2) ? (m_yc ^ ((m_fc >> 1) & 1)) : m_yc;
        xx = (m_mode == 2) ? (m_xc ^ (m_fc & 1)) : m_xc;
        t  = bay[yy*4 + xx];
        ew.hs = hs; ew.vs = vs; ew.de = de; ew.cnt = 0; ew.pos = 0;
        en.hs = hs; en.vs = vs; en.de = de; en.cnt = cnt_on; en.pos = m_yc*4 + m_xc;
        if (!de || m_mode == 3) begin
            ew.colr = '0;
            en.colr = '0;
        end else begin
            ew.colr = {wid(cw[14:10]), wid(cw[9:5]), wid(cw[4:0])};
            en.colr = {9'd0, nar(cn[23:16], t, m_mode), nar(cn[15:8], t, m_mode),
                       nar(cn[7:0], t, m_mode)};
        end
        qw.push_back(ew);
        qn.push_back(en);
        vs_edge = vs && !m_vs_p;
        if (vs_edge) begin
            m_mode = int'(mode);
            m_yc   = 0;
            m_fc   = (m_fc + 1) % 4;
        end else if (m_de_p && !de) begin
            m_yc = (m_yc + 1) % 4;
        end
        m_xc   = de ? (m_xc + 1) % 4 : 0;
        m_de_p = de;
        m_vs_p = vs;
    endtask

    task automatic step(input logic hs, input logic vs, input logic de,
                        input logic [14:0] cw, input logic [23:0] cn);
        exp_t e;
        @(negedge clk_pix);
        if (qw.size() == LW) begin
            e = qw.pop_front();
            cmp("w_hsync", vw.out_hsync, e.hs);
            cmp("w_vsync", vw.out_vsync, e.vs);
            cmp("w_de",    vw.out_de,    e.de);
            cmp("w_colr",  vw.out_colr,  e.colr);
        end
        if (qn.size() == LN) begin
            e = qn.pop_front();
            cmp("n_hsync", vn.out_hsync, e.hs);
            cmp("n_vsync", vn.out_vsync, e.vs);
            cmp("n_de",    vn.out_de,    e.de);
            cmp("n_colr",  vn.out_colr,  e.colr);
            if (e.cnt && e.de) begin
                if (vn.out_colr[14:10] == 5'h01) begin
                    n_one++;
                    pos_ones[e.pos]++;
                end else if (vn.out_colr[14:10] == 5'h00) begin
                    n_zero++;
                end
            end
        end
        drive_push(hs, vs, de, cw, cn);
    endtask

    // model and queues restart; pipeline holds reset values for LAT-1 more samples
    task automatic model_reset();
        exp_t r;
        m_xc = 0; m_yc = 0; m_fc = 0; m_mode = 0; m_de_p = 0; m_vs_p = 0;
        qw.delete(); qn.delete();
        r.hs = 0; r.vs = 0; r.de = 0; r.colr = '0; r.cnt = 0; r.pos = 0;
        repeat (LW-1) qw.push_back(r);
        repeat (LN-1) qn.push_back(r);
    endtask

    task automatic chk_reset(input string tag);
        cmp({tag, "_w_hs"}, vw.out_hsync, 1'b0);
        cmp({tag, "_w_vs"}, vw.out_vsync, 1'b0);
        cmp({tag, "_w_de"}, vw.out_de, 1'b0);
        cmp({tag, "_w_colr"}, vw.out_colr, 24'd0);
        cmp({tag, "_n_hs"}, vn.out_hsync, 1'b0);
        cmp({tag, "_n_vs"}, vn.out_vsync, 1'b0);
        cmp({tag, "_n_de"}, vn.out_de, 1'b0);
        cmp({tag, "_n_colr"}, vn.out_colr, 15'd0);
    endtask

    task automatic set_idle();
        vw.in_hsync = 0; vw.in_vsync = 0; vw.in_de = 0; vw.in_colr = '0;
        vn.in_hsync = 0; vn.in_vsync = 0; vn.in_de = 0; vn.in_colr = '0;
    endtask

    task automatic vsync();
        step(0, 1, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        step(0, 0, 0, '0, '0);
    endtask

    task automatic line(input int n, input logic [14:0] cw, input logic [23:0] cn);
        repeat (n) step(0, 0, 1, cw, cn);
        step(1, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0);
    endtask

    task automatic block4(input logic [14:0] cw, input logic [23:0] cn);
        repeat (4) line(4, cw, cn);
    endtask

    task automatic drain();
        repeat (LN + 1) step(0, 0, 0, '0, '0);
    endtask

    initial begin
        set_idle();
        // power-on reset, checked before any clock edge
        #1 rst_pix_n = 1'b0;
        #2 chk_reset("por");
        repeat (2) @(negedge clk_pix);
        rst_pix_n = 1'b1;
        model_reset();
        drive_push(0, 0, 0, '0, '0);

        // mode 0: widen replication, narrow truncation, DE-low blanking
        mode = 2'd0;
        vsync();
        step(0, 0, 1, {5'h1F, 5'h10, 5'h00}, {8'hFF, 8'h07, 8'h80});
        step(0, 0, 1, {3{5'h10}}, {3{8'h07}});
        step(0, 0, 1, {3{5'h00}}, {3{8'hFF}});
        step(0, 0, 1, {3{5'h1F}}, {8'h08, 8'hF8, 8'h7F});
        step(0, 0, 0, {3{5'h1F}}, {3{8'hFF}});
        step(1, 0, 0, {3{5'h1F}}, {3{8'hFF}});
        step(0, 0, 0, '0, '0);

        // mode 1: spatial dither over a 4x4 block
        mode = 2'd1;
        vsync();
        n_one = 0; n_zero = 0;
        cnt_on = 1;
        block4({3{5'h04}}, {3{8'h04}});
        cnt_on = 0;
        drain();
        cmp("m1_ones", n_one, 8);
        cmp("m1_zeros", n_zero, 8);
        block4({3{5'h1E}}, {3{8'hFE}});
        line(8, {3{5'h04}}, {3{8'h04}});
        // vsync edge in the same cycle as DE falling
        repeat (3) step(0, 0, 1, '0, {3{8'h04}});
        vsync();
        block4('0, {3{8'h04}});

        // mode 2: spatio-temporal dither across four frames
        mode = 2'd2;
        for (int p = 0; p < 16; p++) pos_ones[p] = 0;
        repeat (4) begin
            vsync();
            cnt_on = 1;
            block4('0, {3{8'h04}});
            cnt_on = 0;
        end
        drain();
        for (int p = 0; p < 16; p++) cmp($sformatf("m2_pos%0d", p), pos_ones[p], 2);

        // blank mode requested mid-frame takes effect at the next vsync
        mode = 2'd0;
        vsync();
        line(4, {3{5'h10}}, {3{8'hFF}});
        mode = 2'd3;
        line(4, {3{5'h10}}, {3{8'hFF}});
        vsync();
        line(4, {3{5'h10}}, {3{8'hFF}});
        drain();

        // asynchronous reset in the middle of an active line
        mode = 2'd1;
        vsync();
        repeat (4) step(0, 0, 1, {3{5'h1F}}, {3{8'hFF}});
        #2 rst_pix_n = 1'b0;
        #1 chk_reset("midline");
        set_idle();
        repeat (3) @(negedge clk_pix);
        rst_pix_n = 1'b1;
        model_reset();
        drive_push(0, 0, 0, '0, '0);
        // first post-reset frame runs plain until the next vsync edge
        line(4, {3{5'h1F}}, {3{8'h04}});
        block4('0, {3{8'h04}});
        vsync();
        block4('0, {3{8'h04}});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
